// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - pipeline hazard controller: forwarding, load-use/RAW stalls, redirects, divider sequencing
//
// Purpose:
//   Central hazard unit for the 5-stage pipeline. It generates the stall and
//   flush controls for the F/D, D/E and E/M pipe registers and the E-stage
//   operand forwarding selects. It also sequences the multi-cycle iterative
//   divider in E, holding the front of the pipe until the result is ready.
//
// Configuration macro: HAZARD_FORWARDING_EN
//   defined   - M/W results are forwarded to the E-stage operand muxes.
//   undefined - forwarding selects are tied to 00 and any D-stage source
//               that matches a pending E or M write is stalled in D instead.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   Rs1D, Rs2D        D-stage source registers
//   Rs1E, Rs2E, RdE   E-stage sources and destination
//   RdM, RdW          M/W-stage destinations
//   LoadE             E instruction is a load
//   RegWriteM/W       M/W-stage register write enables
//   PCSrcTakenE       branch/jump in E redirects the PC
//   DivStartE         E instruction is a divide/remainder
//   StallF/D/E        hold PC, F/D and D/E registers
//   FlushD/E/M        bubble F/D, D/E and E/M registers
//   ForwardAE/BE      operand selects: 00 regfile, 01 W result, 10 M ALU result
//   DivBusy           divider sequencing active
//   DivDoneE          divider result valid this cycle

module hazard_unit #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int DIV_CYCLES     = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REG_ADDR_WIDTH-1:0] Rs1D,
  input  logic [REG_ADDR_WIDTH-1:0] Rs2D,
  input  logic [REG_ADDR_WIDTH-1:0] Rs1E,
  input  logic [REG_ADDR_WIDTH-1:0] Rs2E,
  input  logic [REG_ADDR_WIDTH-1:0] RdE,
  input  logic [REG_ADDR_WIDTH-1:0] RdM,
  input  logic [REG_ADDR_WIDTH-1:0] RdW,
  input  logic                      LoadE,
  input  logic                      RegWriteM,
  input  logic                      RegWriteW,
  input  logic                      PCSrcTakenE,
  input  logic                      DivStartE,
  output logic                      StallF,
  output logic                      StallD,
  output logic                      StallE,
  output logic                      FlushD,
  output logic                      FlushE,
  output logic                      FlushM,
  output logic [1:0]                ForwardAE,
  output logic [1:0]                ForwardBE,
  output logic                      DivBusy,
  output logic                      DivDoneE
);

  localparam int CW = $clog2(DIV_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

  div_state_t    state;
  logic [CW-1:0] count;
  logic          div_busy_q;
  logic          div_done_q;

  logic          div_hold;
  logic          lw_stall;
  logic          raw_stall;

  // ---------------------------------------------------------------------------
  // Forwarding / RAW detection
  // ---------------------------------------------------------------------------
`ifdef HAZARD_FORWARDING_EN
  function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_WIDTH-1:0] rs);
    logic [1:0] sel;
    sel = 2'b00;
    // M is the younger producer, so it wins over W; x0 is never forwarded.
    if (RegWriteM && (RdM != '0) && (RdM == rs))
      sel = 2'b10;
    else if (RegWriteW && (RdW != '0) && (RdW == rs))
      sel = 2'b01;
    return sel;
  endfunction

  assign ForwardAE = fwd_sel(Rs1E);
  assign ForwardBE = fwd_sel(Rs2E);
  assign raw_stall = 1'b0;
`else
  logic raw_e;
  logic raw_m;
  logic fwd_unused;

  assign ForwardAE = 2'b00;
  assign ForwardBE = 2'b00;

  // RegWriteE is not visible here, so any non-zero RdE (or a load) is treated
  // as a pending write. W needs no stall because the regfile is write-first.
  assign raw_e = (LoadE || (RdE != '0)) && (RdE != '0) &&
                 ((RdE == Rs1D) || (RdE == Rs2D));
  assign raw_m = RegWriteM && (RdM != '0) &&
                 ((RdM == Rs1D) || (RdM == Rs2D));
  assign raw_stall = raw_e || raw_m;

  // E-stage sources and W-stage write info only matter when forwarding.
  assign fwd_unused = ^{Rs1E, Rs2E, RdW, RegWriteW};
`endif

  assign lw_stall = LoadE && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));

  // ---------------------------------------------------------------------------
  // Stall / flush equations
  // ---------------------------------------------------------------------------
  // The divide holds in E from the cycle it is first seen through the last
  // BUSY cycle. Flushes are suppressed during that window so the held divide
  // is never bubbled out of D/E.
  assign div_hold = ((state == IDLE) && DivStartE) || (state == BUSY);

  assign StallF = lw_stall || raw_stall || div_hold;
  assign StallD = lw_stall || raw_stall || div_hold;
  assign StallE = div_hold;
  assign FlushM = div_hold;
  assign FlushD = PCSrcTakenE && !div_hold;
  assign FlushE = (lw_stall || raw_stall || PCSrcTakenE) && !div_hold;

  assign DivBusy  = div_busy_q;
  assign DivDoneE = div_done_q;

  // ---------------------------------------------------------------------------
  // Divider sequencer
  // ---------------------------------------------------------------------------
  // BUSY lasts DIV_CYCLES cycles (count DIV_CYCLES-1 down to 0). DONE lasts a
  // single cycle and ignores DivStartE, so a back-to-back divide restarts from
  // IDLE one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      count      <= '0;
      div_busy_q <= 1'b0;
      div_done_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          div_done_q <= 1'b0;
          if (DivStartE) begin
            state      <= BUSY;
            count      <= CW'(DIV_CYCLES - 1);
            div_busy_q <= 1'b1;
          end
        end
        BUSY: begin
          if (count == '0) begin
            state      <= DONE;
            div_done_q <= 1'b1;
          end else begin
            count <= count - 1'b1;
          end
        end
        DONE: begin
          state      <= IDLE;
          div_busy_q <= 1'b0;
          div_done_q <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          count      <= '0;
          div_busy_q <= 1'b0;
          div_done_q <= 1'b0;
        end
      endcase
    end
  end

  // Decode keeps branches and divides exclusive; a redirect while the divide
  // is held would be silently dropped, so flag it in simulation.
  redirect_during_div_hold: assert property (
    @(posedge clk) disable iff (rst) !(PCSrcTakenE && div_hold)
  );

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - randomized self-checking bench for hazard_unit against a cycle-count reference model

module tb_hazard_unit;

  localparam int AW = 5;
  localparam int DC = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic          LoadE, RegWriteM, RegWriteW, PCSrcTakenE, DivStartE;
  logic          StallF, StallD, StallE, FlushD, FlushE, FlushM;
  logic [1:0]    ForwardAE, ForwardBE;
  logic          DivBusy, DivDoneE;

  always #5 clk = ~clk;

  hazard_unit #(.REG_ADDR_WIDTH(AW), .DIV_CYCLES(DC)) dut (
    .clk(clk), .rst(rst),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .LoadE(LoadE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .PCSrcTakenE(PCSrcTakenE), .DivStartE(DivStartE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .DivBusy(DivBusy), .DivDoneE(DivDoneE)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: age = cycles elapsed since the divide was first seen in
  // E (-1 when no divide is in flight). Hold covers ages 0..DC, the done
  // pulse is age DC+1.
  int age = -1;
  int cur = -1;
  bit model_valid = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int fwd_ref(input logic [AW-1:0] rs);
    if (RegWriteM && RdM != 0 && RdM == rs) return 2;
    if (RegWriteW && RdW != 0 && RdW == rs) return 1;
    return 0;
  endfunction

  function automatic bit hold_now();
    int c;
    c = (age < 0 && DivStartE) ? 0 : age;
    return (c >= 0 && c <= DC);
  endfunction

  task automatic eval_check();
    bit hold, lw, raw, d_uses_e, d_uses_m;
    int fa, fb;
    cur  = (age < 0 && DivStartE) ? 0 : age;
    hold = (cur >= 0 && cur <= DC);
    d_uses_e = (RdE == Rs1D) || (RdE == Rs2D);
    d_uses_m = (RdM == Rs1D) || (RdM == Rs2D);
    lw = LoadE && RdE != 0 && d_uses_e;
`ifdef HAZARD_FORWARDING_EN
    fa  = fwd_ref(Rs1E);
    fb  = fwd_ref(Rs2E);
    raw = 1'b0;
`else
    fa  = 0;
    fb  = 0;
    raw = (RdE != 0 && d_uses_e) || (RegWriteM && RdM != 0 && d_uses_m);
`endif
    if (model_valid) begin
      check("StallF",    StallF,    lw | raw | hold);
      check("StallD",    StallD,    lw | raw | hold);
      check("StallE",    StallE,    hold);
      check("FlushM",    FlushM,    hold);
      check("FlushD",    FlushD,    PCSrcTakenE & !hold);
      check("FlushE",    FlushE,    (lw | raw | PCSrcTakenE) & !hold);
      check("ForwardAE", ForwardAE, fa);
      check("ForwardBE", ForwardBE, fb);
      check("DivBusy",   DivBusy,   age >= 1);
      check("DivDoneE",  DivDoneE,  age == DC + 1);
    end
  endtask

  task automatic tick();
    #1;
    eval_check();
    @(posedge clk);
    if (rst) begin
      age = -1;
      model_valid = 1'b1;
    end else if (model_valid) begin
      age = (cur >= 0 && cur < DC + 1) ? cur + 1 : -1;
    end
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0;
    RdE = '0; RdM = '0; RdW = '0;
    LoadE = 0; RegWriteM = 0; RegWriteW = 0; PCSrcTakenE = 0; DivStartE = 0;
  endtask

  initial begin
    int held, done_cnt, done_at;
    clear_inputs();
    rst = 1'b1;
    @(negedge clk);
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("rst_divbusy", DivBusy,  1'b0);
    check("rst_divdone", DivDoneE, 1'b0);
    check("rst_stalle",  StallE,   1'b0);
    check("rst_flushm",  FlushM,   1'b0);
    tick();

    // Forwarding priority: M over W, then W, then regfile.
    RegWriteM = 1; RdM = 5; RegWriteW = 1; RdW = 5; Rs1E = 5;
`ifdef HAZARD_FORWARDING_EN
    #1 check("fwd_m_prio", ForwardAE, 2'b10);
`else
    #1 check("fwd_tied",   ForwardAE, 2'b00);
`endif
    tick();
    RdM = 0;
`ifdef HAZARD_FORWARDING_EN
    #1 check("fwd_w", ForwardAE, 2'b01);
`endif
    tick();
    RdW = 0;
    #1 check("fwd_none", ForwardAE, 2'b00);
    tick();
    clear_inputs();

    // Load-use.
    LoadE = 1; RdE = 7; Rs2D = 7;
    #1;
    check("lu_stallf", StallF, 1'b1);
    check("lu_stalld", StallD, 1'b1);
    check("lu_flushe", FlushE, 1'b1);
    check("lu_flushd", FlushD, 1'b0);
    tick();
    RdE = 0;
    #1;
    check("lu_x0_stallf", StallF, 1'b0);
    check("lu_x0_flushe", FlushE, 1'b0);
    tick();
    clear_inputs();

    // Taken branch.
    PCSrcTakenE = 1;
    #1;
    check("br_flushd", FlushD, 1'b1);
    check("br_flushe", FlushE, 1'b1);
    check("br_stallf", StallF, 1'b0);
    tick();
    clear_inputs();

    // Single divide: hold DC+1 cycles, one done pulse right after.
    held = 0; done_cnt = 0; done_at = -1;
    DivStartE = 1;
    for (int i = 0; i < DC + 4; i++) begin
      #1;
      if (StallE && FlushM && StallF) held++;
      if (DivDoneE) begin
        done_cnt++;
        done_at = i;
      end
      tick();
      DivStartE = 0;
    end
    check("div_hold_len", held,     DC + 1);
    check("div_done_cnt", done_cnt, 1);
    check("div_done_at",  done_at,  DC + 1);

    // Reset on the second BUSY cycle aborts without a done pulse.
    DivStartE = 1;
    tick();
    DivStartE = 0;
    tick();
    rst = 1;
    tick();
    rst = 0;
    #1;
    check("abort_divbusy", DivBusy, 1'b0);
    check("abort_stalle",  StallE,  1'b0);
    done_cnt = 0;
    for (int i = 0; i < DC + 3; i++) begin
      #1;
      if (DivDoneE) done_cnt++;
      tick();
    end
    check("abort_no_done", done_cnt, 0);

    // Load-use concurrent with a divide start: stalls ORed, no flush.
    LoadE = 1; RdE = 3; Rs1D = 3; DivStartE = 1;
    #1;
    check("lu_div_stallf", StallF, 1'b1);
    check("lu_div_stalle", StallE, 1'b1);
    check("lu_div_flushe", FlushE, 1'b0);
    tick();
    clear_inputs();
    for (int i = 0; i < DC + 2; i++) tick();

    // Randomized traffic; small register range to provoke matches.
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 99) == 0);
      Rs1D      = AW'($urandom_range(0, 7));
      Rs2D      = AW'($urandom_range(0, 7));
      Rs1E      = AW'($urandom_range(0, 7));
      Rs2E      = AW'($urandom_range(0, 7));
      RdE       = AW'($urandom_range(0, 7));
      RdM       = AW'($urandom_range(0, 7));
      RdW       = AW'($urandom_range(0, 7));
      LoadE     = $urandom_range(0, 3) == 0;
      RegWriteM = $urandom_range(0, 1) == 1;
      RegWriteW = $urandom_range(0, 1) == 1;
      DivStartE = $urandom_range(0, 7) == 0;
      PCSrcTakenE = hold_now() ? 1'b0 : ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
